hps_binary_pixel_streamer: RTL and testbench

- Sits between the SDRAM controller read port 1 (16-bit pixel words from the captured frame) and the HPS PIO data/handshake registers.
- On a start request it reads one full frame, one pixel at a time.
- Each pixel is thresholded to one bit, and 8 bits are packed into a byte.
- Each byte is handed to the HPS over a four-phase valid/ack handshake, so the software reader sets the pace instead of a free-running counter clock.

---
 rtl/hps_binary_pixel_streamer.sv | 170 +++++++++++++++++
 tb/tb_hps_binary_pixel_streamer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hps_binary_pixel_streamer.sv
// Streams one captured frame to the HPS as thresholded 1-bit pixels packed into bytes,
// paced by a four-phase valid/ack handshake. Define HPS_STREAM_CHECKSUM_EN to add oCHECKSUM.
module hps_binary_pixel_streamer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RD_LAT   = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iABORT,
  input  logic [7:0]  iTHRESH,
  input  logic [15:0] iDATA,
  output logic        oRD,
  output logic [7:0]  oBYTE,
  output logic        oVALID,
  input  logic        iACK,
  output logic [9:0]  oX,
  output logic [8:0]  oY,
  output logic        oBUSY,
  output logic        oFRAME_DONE
`ifdef HPS_STREAM_CHECKSUM_EN
  ,
  output logic [15:0] oCHECKSUM
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PACK, S_PRESENT, S_RELEASE, S_DONE
  } state_t;

  localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_END     = 9'(V_ACTIVE);
  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t      state_q, state_d;
  logic        start_prev_q, start_edge_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [1:0]  wait_q, wait_d;

  logic        pixel_bit;
  logic [7:0]  shift_new;
  logic        start_accept;
  logic        byte_done;
  logic        unused_data_hi;

  // Only the low byte carries the luma used for binarization.
  assign unused_data_hi = ^iDATA[15:8];

  assign pixel_bit    = (iDATA[7:0] > iTHRESH);
  assign shift_new    = {shift_q[6:0], pixel_bit};
  assign start_accept = (state_q == S_IDLE) && start_edge_q && !iABORT;
  assign byte_done    = (state_q == S_PACK) && (bit_cnt_q == 3'd7) && !iABORT;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    x_d       = x_q;
    y_d       = y_q;
    wait_d    = wait_q;
    if (iABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge_q) begin
            x_d       = 10'd0;
            y_d       = 9'd0;
            bit_cnt_d = 3'd0;
            shift_d   = 8'd0;
            state_d   = S_FETCH;
          end
        end
        S_FETCH: begin
          wait_d  = 2'd0;
          state_d = (RD_LAT > 1) ? S_WAIT : S_PACK;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) state_d = S_PACK;
          else                     wait_d  = wait_q + 2'd1;
        end
        S_PACK: begin
          shift_d = shift_new;
          if (x_q == X_LAST) begin
            x_d = 10'd0;
            y_d = y_q + 9'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
          if (bit_cnt_q == 3'd7) begin
            byte_d    = shift_new;
            bit_cnt_d = 3'd0;
            state_d   = S_PRESENT;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_FETCH;
          end
        end
        S_PRESENT: begin
          if (iACK) state_d = S_RELEASE;
        end
        S_RELEASE: begin
          // Last pixel packed once the column wrap has pushed the line count to V_ACTIVE.
          if (!iACK) state_d = ((x_q == 10'd0) && (y_q == Y_END)) ? S_DONE : S_FETCH;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_q       <= 8'd0;
      x_q          <= 10'd0;
      y_q          <= 9'd0;
      wait_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= iSTART;
      start_edge_q <= iSTART & ~start_prev_q;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wait_q       <= wait_d;
    end
  end

  assign oRD         = (state_q == S_FETCH);
  assign oVALID      = (state_q == S_PRESENT);
  assign oBUSY       = (state_q != S_IDLE);
  assign oFRAME_DONE = (state_q == S_DONE);
  assign oBYTE       = byte_q;
  assign oX          = x_q;
  assign oY          = y_q;

`ifdef HPS_STREAM_CHECKSUM_EN
  logic [15:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (start_accept)   cks_d = 16'd0;
    else if (byte_done) cks_d = cks_q + {8'h00, shift_new};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) cks_q <= 16'd0;
    else      cks_q <= cks_d;
  end

  assign oCHECKSUM = cks_q;
`else
  logic unused_cks_terms;
  assign unused_cks_terms = start_accept ^ byte_done;
`endif

endmodule

// File: tb/tb_hps_binary_pixel_streamer.sv
// Directed bench for hps_binary_pixel_streamer: table-driven frames plus handshake, reset and abort corners.
module tb_hps_binary_pixel_streamer;
  localparam int H = 16;
  localparam int V = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, abort = 1'b0, ack = 1'b0;
  logic [7:0]  thresh = 8'd92;
  logic [15:0] data = 16'h0000;
  logic        rd, valid, busy, fdone;
  logic [7:0]  byte_o;
  logic [9:0]  x;
  logic [8:0]  y;

  logic        start3 = 1'b0, abort3 = 1'b0, ack3 = 1'b0;
  logic [15:0] data3 = 16'h5AC8;
  logic        rd3, valid3, busy3, fdone3;
  logic [7:0]  byte3;
  logic [9:0]  x3;
  logic [8:0]  y3;
`ifdef HPS_STREAM_CHECKSUM_EN
  logic [15:0] cks, cks3;
`endif

  hps_binary_pixel_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .RD_LAT(1)) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iABORT(abort), .iTHRESH(thresh),
    .iDATA(data), .oRD(rd), .oBYTE(byte_o), .oVALID(valid), .iACK(ack),
    .oX(x), .oY(y), .oBUSY(busy), .oFRAME_DONE(fdone)
`ifdef HPS_STREAM_CHECKSUM_EN
    , .oCHECKSUM(cks)
`endif
  );

  hps_binary_pixel_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .RD_LAT(3)) dut3 (
    .iCLK(clk), .iRST(rst), .iSTART(start3), .iABORT(abort3), .iTHRESH(thresh),
    .iDATA(data3), .oRD(rd3), .oBYTE(byte3), .oVALID(valid3), .iACK(ack3),
    .oX(x3), .oY(y3), .oBUSY(busy3), .oFRAME_DONE(fdone3)
`ifdef HPS_STREAM_CHECKSUM_EN
    , .oCHECKSUM(cks3)
`endif
  );

  int total = 0;
  int bad = 0;
  int rd_cnt = 0, rd_base = 0, rd3_cnt = 0;
  logic [7:0] d_even = 8'd0, d_odd = 8'd0;

  // Read-FIFO model: on each read request present the next pixel (upper byte is junk).
  always @(negedge clk) begin
    if (rd) begin
      data = (((rd_cnt - rd_base) % 2) == 0) ? {8'hA5, d_even} : {8'hA5, d_odd};
      rd_cnt++;
    end
    if (rd3) rd3_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  d_even;
    logic [7:0]  d_odd;
    logic [7:0]  thr;
    logic [7:0]  exp_byte;
    logic [15:0] exp_cks;
  } vec_t;
  vec_t vecs[4];

  // Full frame with iACK echoing oVALID three cycles later.
  task automatic run_frame(input int idx);
    logic [3:0] vh;
    logic prev_v, finished;
    int nbytes, ndone;
    vh = 4'd0; prev_v = 1'b0; finished = 1'b0; nbytes = 0; ndone = 0;
    d_even = vecs[idx].d_even; d_odd = vecs[idx].d_odd; thresh = vecs[idx].thr;
    rd_base = rd_cnt;
    start = 1'b1;
    for (int c = 0; c < 1500 && !finished; c++) begin
      @(negedge clk);
      if (c == 4) start = 1'b0;
      vh = {vh[2:0], valid};
      ack = vh[3];
      if (valid) begin
        chk("frame_byte", {24'd0, byte_o}, {24'd0, vecs[idx].exp_byte});
        if (!prev_v) nbytes++;
      end
      prev_v = valid;
      if (fdone) begin
        ndone++;
        chk("y_at_done", {23'd0, y}, V);
`ifdef HPS_STREAM_CHECKSUM_EN
        chk("checksum_at_done", {16'd0, cks}, {16'd0, vecs[idx].exp_cks});
`endif
      end
      if (ndone > 0 && !busy) finished = 1'b1;
    end
    ack = 1'b0;
    start = 1'b0;
    chk("frame_finished", {31'd0, finished}, 1);
    chk("frame_nbytes", nbytes, 4);
    chk("frame_ndone", ndone, 1);
    chk("frame_reads", rd_cnt - rd_base, H * V);
    $display("frame %0d: bytes=%0d reads=%0d done_pulses=%0d exp_byte=%02h exp_cks=%04h",
             idx, nbytes, rd_cnt - rd_base, ndone, vecs[idx].exp_byte, vecs[idx].exp_cks);
  endtask

  initial begin
    logic seen, bad_seen;
    int lat, snap;
    vecs[0] = '{d_even: 8'd200, d_odd: 8'd10, thr: 8'd92, exp_byte: 8'hAA, exp_cks: 16'h02A8};
    vecs[1] = '{d_even: 8'd93,  d_odd: 8'd93, thr: 8'd92, exp_byte: 8'hFF, exp_cks: 16'h03FC};
    vecs[2] = '{d_even: 8'd92,  d_odd: 8'd92, thr: 8'd92, exp_byte: 8'h00, exp_cks: 16'h0000};
    vecs[3] = '{d_even: 8'd92,  d_odd: 8'd93, thr: 8'd92, exp_byte: 8'h55, exp_cks: 16'h0154};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rd", {31'd0, rd}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, fdone}, 0);
    chk("rst_byte", {24'd0, byte_o}, 0);
    chk("rst_xy", {13'd0, x, y}, 0);

    for (int i = 0; i < 4; i++) run_frame(i);

    // iACK already high when each byte appears: one-cycle present, release waits for ack low.
    d_even = 8'd93; d_odd = 8'd93; thresh = 8'd92;
    rd_base = rd_cnt;
    ack = 1'b1;
    start = 1'b1;
    for (int b = 0; b < 4; b++) begin
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        if (c == 3) start = 1'b0;
        if (valid) seen = 1'b1;
      end
      chk("ackhi_seen", {31'd0, seen}, 1);
      chk("ackhi_byte", {24'd0, byte_o}, 32'hFF);
      @(negedge clk);
      chk("ackhi_valid_1cyc", {31'd0, valid}, 0);
      repeat (2) @(negedge clk);
      chk("ackhi_release_hold", {29'd0, valid, rd, busy}, 1);
      ack = 1'b0;
      @(negedge clk);
      if (b < 3) chk("ackhi_next_fetch", {31'd0, rd}, 1);
      else       chk("ackhi_done", {31'd0, fdone}, 1);
      ack = 1'b1;
      $display("ack-high byte %0d: 0xff presented once", b);
    end
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    chk("ackhi_idle", {31'd0, busy}, 0);
    chk("ackhi_reads", rd_cnt - rd_base, H * V);

    // Reset while a byte is presented, then restart from the origin.
    d_even = 8'd200; d_odd = 8'd10;
    rd_base = rd_cnt;
    start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk("rstmid_seen", {31'd0, seen}, 1);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_outs", {28'd0, rd, valid, busy, fdone}, 0);
    chk("rstmid_byte", {24'd0, byte_o}, 0);
    chk("rstmid_xy", {13'd0, x, y}, 0);
`ifdef HPS_STREAM_CHECKSUM_EN
    chk("rstmid_cks", {16'd0, cks}, 0);
`endif
    @(negedge clk);
    rd_base = rd_cnt;
    start = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (rd) seen = 1'b1;
    end
    chk("restart_latency", lat, 2);
    chk("restart_xy", {13'd0, x, y}, 0);
    start = 1'b0;
    $display("reset mid-present: restart latency=%0d", lat);

    // Abort in WAIT (RD_LAT=3) after an ignored start edge while busy.
    start3 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rd3) seen = 1'b1;
    end
    chk("abort_first_rd", {31'd0, seen}, 1);
    start3 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rd3) seen = 1'b1;
    end
    chk("abort_second_rd", {31'd0, seen}, 1);
    start3 = 1'b1;
    @(negedge clk);
    chk("abort_w0_busy", {30'd0, busy3, rd3}, 2);
    @(negedge clk);
    chk("abort_no_restart_x", {22'd0, x3}, 1);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    chk("abort_outs", {29'd0, busy3, rd3, valid3}, 0);
    snap = rd3_cnt;
    bad_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rd3 || fdone3 || busy3) bad_seen = 1'b1;
    end
    chk("abort_quiet", {31'd0, bad_seen}, 0);
    chk("abort_reads", rd3_cnt - snap, 0);
    $display("abort in wait: busy=%0d reads_after=%0d", busy3, rd3_cnt - snap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
